// File: rtl/hazard_ctrl.sv
//==============================================================================
// Module      : hazard_ctrl
// Description : Five-stage pipeline hazard unit: forwarding, load-use stall,
//               branch flush and multi-cycle EX wait with timeout.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       readAddress1_ID,
    input  logic [4:0]       readAddress2_ID,
    input  logic [4:0]       readAddress1_EX,
    input  logic [4:0]       readAddress2_EX,
    input  logic [4:0]       writeAddress_EX,
    input  logic             regWrite_EX,
    input  logic [1:0]       resultSrc_EX,
    input  logic [4:0]       writeAddress_MEM,
    input  logic             regWrite_MEM,
    input  logic [4:0]       writeAddress_WB,
    input  logic             regWrite_WB,
    input  logic             PCSrc_EX,
    input  logic             mcStart_EX,
    input  logic             mcDone,
    output logic [1:0]       forwardA_EX,
    output logic [1:0]       forwardB_EX,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             stall_EX,
    output logic             flush_ID,
    output logic             flush_EX,
    output logic             flush_MEM,
    output logic             mcTimeout,
    output logic [CNT_W-1:0] stallCount
);

    localparam int                WCNT_W    = $clog2(MC_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MC_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_MCWAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic                timeout_q, timeout_d;
    logic                load_haz;

    function automatic logic [1:0] fwd_sel(input logic [4:0] ra,
                                           input logic [4:0] wa_mem, input logic rw_mem,
                                           input logic [4:0] wa_wb,  input logic rw_wb);
        if (rw_mem && (wa_mem != 5'd0) && (wa_mem == ra))
            return 2'b10;
        else if (rw_wb && (wa_wb != 5'd0) && (wa_wb == ra))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign forwardA_EX = fwd_sel(readAddress1_EX, writeAddress_MEM, regWrite_MEM,
                                 writeAddress_WB, regWrite_WB);
    assign forwardB_EX = fwd_sel(readAddress2_EX, writeAddress_MEM, regWrite_MEM,
                                 writeAddress_WB, regWrite_WB);

    assign load_haz = (resultSrc_EX == 2'b01) && regWrite_EX && (writeAddress_EX != 5'd0) &&
                      ((writeAddress_EX == readAddress1_ID) || (writeAddress_EX == readAddress2_ID));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        stall_IF   = 1'b0;
        stall_ID   = 1'b0;
        stall_EX   = 1'b0;
        flush_ID   = 1'b0;
        flush_EX   = 1'b0;
        flush_MEM  = 1'b0;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (PCSrc_EX) begin
                    flush_ID = 1'b1;
                    flush_EX = 1'b1;
                end else if (mcStart_EX && !mcDone) begin
                    stall_IF   = 1'b1;
                    stall_ID   = 1'b1;
                    stall_EX   = 1'b1;
                    flush_MEM  = 1'b1;
                    state_d    = ST_MCWAIT;
                    wait_cnt_d = WCNT_W'(1);
                end else if (mcStart_EX && mcDone) begin
                    // Result is ready in the same cycle: EX completes normally.
                    state_d = ST_RUN;
                end else if (load_haz) begin
                    stall_IF = 1'b1;
                    stall_ID = 1'b1;
                    flush_EX = 1'b1;
                end
            end
            ST_MCWAIT: begin
                if (mcDone) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCNT_LAST) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    stall_IF   = 1'b1;
                    stall_ID   = 1'b1;
                    stall_EX   = 1'b1;
                    flush_MEM  = 1'b1;
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            if (stall_IF && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign mcTimeout  = timeout_q;
    assign stallCount = stall_cnt_q;

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core: consumes the register addresses and control bits leaving the ID/EX, EX/MEM and MEM/WB registers, and drives the stall, flush and forwarding controls back into those registers and the EX operand muxes. Handles data forwarding, load-use stalls, taken branch/jump flushes, and a multi-cycle EX operation (mul/div) through a small wait FSM with timeout. Also keeps a saturating stall-cycle counter for performance readout.

## Interface
- MC_TIMEOUT, 64: maximum MCWAIT cycles before a forced release (≥2)
- CNT_W, 16: width of stall-cycle counter

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- readAddress1_ID, readAddress2_ID  in  5  source regs of instruction in ID
- readAddress1_EX, readAddress2_EX  in  5  source regs of instruction in EX
- writeAddress_EX, regWrite_EX  in  5/1  destination and write-enable in EX
- resultSrc_EX  in  2  result select in EX; 2'b01 = load
- writeAddress_MEM, regWrite_MEM  in  5/1  destination and write-enable in MEM
- writeAddress_WB, regWrite_WB  in  5/1  destination and write-enable in WB
- PCSrc_EX  in  1  branch taken or jump resolved in EX
- mcStart_EX  in  1  level: multi-cycle op occupies EX
- mcDone  in  1  multi-cycle unit result valid (one-cycle pulse)
- forwardA_EX, forwardB_EX  out  2  00 regfile, 01 from WB, 10 from MEM
- stall_IF, stall_ID, stall_EX  out  1  hold PC / IF/ID / ID/EX
- flush_ID, flush_EX, flush_MEM  out  1  bubble into IF/ID / ID/EX / EX/MEM
- mcTimeout  out  1  sticky: forced release occurred
- stallCount  out  CNT_W  cycles with stall_IF=1, saturating

## Operation
- Forwarding (combinational, per operand X in {1,2}): 10 if regWrite_MEM, writeAddress_MEM≠0, writeAddress_MEM==readAddressX_EX; else 01 if same against WB; else 00. MEM beats WB.
- Load-use (loadHaz): resultSrc_EX==01, regWrite_EX, writeAddress_EX≠0, matches readAddress1_ID or readAddress2_ID.
- FSM states RUN, MCWAIT; reset to RUN.
- RUN, priority high→low:
  - PCSrc_EX: flush_ID=1, flush_EX=1, no stall (kills any load-use stall).
  - mcStart_EX && !mcDone: stall_IF=stall_ID=stall_EX=1, flush_MEM=1; next MCWAIT, waitCnt←1.
  - loadHaz: stall_IF=stall_ID=1, flush_EX=1.
  - else all stall/flush 0.
  - mcStart_EX && mcDone same cycle: no stall, stay RUN.
- MCWAIT:
  - mcDone: all stall/flush 0 this cycle; next RUN. PCSrc_EX, loadHaz ignored.
  - !mcDone, waitCnt==MC_TIMEOUT-1: forced release, outputs as mcDone case; next RUN; mcTimeout←1.
  - else stall_IF=stall_ID=stall_EX=1, flush_MEM=1; waitCnt+1.
- waitCnt: $clog2(MC_TIMEOUT) bits, internal, cleared on entering RUN.
- stallCount increments on every edge with stall_IF=1; holds at all-ones.
- mcTimeout cleared only by rst_n.

## Timing
- Forward, stall, flush outputs combinational from state and inputs; zero-cycle latency.
- State, waitCnt, stallCount, mcTimeout update on rising clk.
- rst_n low (any time, incl. mid-MCWAIT): state RUN, waitCnt 0, stallCount 0, mcTimeout 0 immediately; stall/flush then follow RUN rules.
- Load-use stall lasts exactly one cycle (bubble moves load to MEM, then forward 10).
- Multi-cycle op starting at cycle N, mcDone at N+k: stalls on N..N+k-1, released on N+k; stallCount += k.
- Timeout: stalls on MC_TIMEOUT-1 cycles, release on cycle MC_TIMEOUT, mcTimeout high after that edge.
- Register x0 never forwarded or load-hazarded.

## Test plan
- Forwarding: MEM writes x5 and WB writes x5, readAddress1_EX=5 → forwardA_EX=10; MEM disabled → 01; writeAddress=0 both → 00.
- Load-use: load to x7 in EX, readAddress2_ID=7 → one cycle stall_IF=stall_ID=flush_EX=1, next cycle 0; stallCount=1.
- Branch vs load-use: PCSrc_EX=1 with loadHaz → flush_ID=flush_EX=1, stall_IF=0, stallCount unchanged.
- Multi-cycle: mcStart_EX held, mcDone at 5th cycle → four stall cycles with flush_MEM=1, release on 5th, state RUN, stallCount=4.
- Timeout, MC_TIMEOUT=8: mcStart_EX held, no mcDone → 7 stall cycles, release on 8th, mcTimeout=1 and stays 1.
- Reset mid-MCWAIT: rst_n low on 3rd wait cycle → stalls drop immediately, stallCount=0, mcTimeout=0, RUN after release.
